// File: rtl/exec_seq_pkg.sv
// Shared types and constants for the LEGv8 execution sequencer: FSM states, opcodes,
// datapath select encodings and the decoded control bundle.
package exec_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_e;

    // Instruction class, chooses the path through EXEC/MEM/WB
    typedef enum logic [2:0] {
        K_NONE,
        K_ALU,
        K_ALUF,
        K_LOAD,
        K_STORE,
        K_CBZ,
        K_BLT,
        K_B
    } kind_e;

    localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
    localparam logic [10:0] OP_ADDS  = 11'b10101011000;
    localparam logic [10:0] OP_SUBS  = 11'b11101011000;
    localparam logic [10:0] OP_LDUR  = 11'b11111000010;
    localparam logic [10:0] OP_LDURB = 11'b00111000010;
    localparam logic [10:0] OP_STUR  = 11'b11111000000;
    localparam logic [10:0] OP_STURB = 11'b00111000000;
    localparam logic [8:0]  OP_MOVZ  = 9'b110100101;
    localparam logic [8:0]  OP_MOVK  = 9'b111100101;
    localparam logic [7:0]  OP_CBZ   = 8'b10110100;
    localparam logic [5:0]  OP_B     = 6'b000101;
    localparam logic [7:0]  OP_BCOND = 8'b01010100;
    localparam logic [3:0]  COND_LT  = 4'b1011;

    localparam logic [2:0]  ALU_PASS_B = 3'b000;
    localparam logic [2:0]  ALU_ADD    = 3'b010;
    localparam logic [2:0]  ALU_SUB    = 3'b011;

    localparam logic [1:0]  SRC_DB     = 2'b00;
    localparam logic [1:0]  SRC_DADDR9 = 2'b01;
    localparam logic [1:0]  SRC_IMM12  = 2'b10;

    localparam logic [3:0]  XFER_NONE  = 4'd0;
    localparam logic [3:0]  XFER_BYTE  = 4'd1;
    localparam logic [3:0]  XFER_DWORD = 4'd8;

    typedef struct packed {
        kind_e      kind;
        logic       reg2loc;
        logic [1:0] alu_src;
        logic [2:0] alu_cntrl;
        logic       mem_to_reg;
        logic       ldurb;
        logic       movz;
        logic       movk;
        logic [3:0] xfer_size;
    } ctrl_t;

endpackage

// File: rtl/exec_seq_decode.sv
// Combinational decoder: instruction register to datapath control bundle plus legal flag.
module exec_seq_decode
    import exec_seq_pkg::*;
(
    input  logic [31:0] ir,
    output ctrl_t       ctrl,
    output logic        legal
);

    // Register/immediate fields are consumed by the datapath, not by the decoder
    logic unused_ir;
    assign unused_ir = ^ir[20:4];

    always_comb begin
        ctrl  = '0;
        legal = 1'b1;
        if (ir[31:21] == OP_ADDS || ir[31:21] == OP_SUBS) begin
            ctrl.kind      = K_ALUF;
            ctrl.alu_src   = SRC_DB;
            ctrl.alu_cntrl = (ir[31:21] == OP_ADDS) ? ALU_ADD : ALU_SUB;
        end else if (ir[31:21] == OP_LDUR || ir[31:21] == OP_LDURB) begin
            ctrl.kind       = K_LOAD;
            ctrl.alu_src    = SRC_DADDR9;
            ctrl.alu_cntrl  = ALU_ADD;
            ctrl.mem_to_reg = 1'b1;
            ctrl.ldurb      = (ir[31:21] == OP_LDURB);
            ctrl.xfer_size  = (ir[31:21] == OP_LDURB) ? XFER_BYTE : XFER_DWORD;
        end else if (ir[31:21] == OP_STUR || ir[31:21] == OP_STURB) begin
            ctrl.kind      = K_STORE;
            ctrl.reg2loc   = 1'b1;
            ctrl.alu_src   = SRC_DADDR9;
            ctrl.alu_cntrl = ALU_ADD;
            ctrl.xfer_size = (ir[31:21] == OP_STURB) ? XFER_BYTE : XFER_DWORD;
        end else if (ir[31:22] == OP_ADDI) begin
            ctrl.kind      = K_ALU;
            ctrl.alu_src   = SRC_IMM12;
            ctrl.alu_cntrl = ALU_ADD;
        end else if (ir[31:23] == OP_MOVZ || ir[31:23] == OP_MOVK) begin
            ctrl.kind      = K_ALU;
            ctrl.reg2loc   = 1'b1;
            ctrl.alu_cntrl = ALU_PASS_B;
            ctrl.movz      = (ir[31:23] == OP_MOVZ);
            ctrl.movk      = (ir[31:23] == OP_MOVK);
        end else if (ir[31:24] == OP_CBZ) begin
            ctrl.kind      = K_CBZ;
            ctrl.reg2loc   = 1'b1;
            ctrl.alu_cntrl = ALU_PASS_B;
        end else if (ir[31:24] == OP_BCOND && ir[3:0] == COND_LT) begin
            ctrl.kind = K_BLT;
        end else if (ir[31:26] == OP_B) begin
            ctrl.kind = K_B;
        end else begin
            legal = 1'b0;
        end
    end

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle control FSM sequencing one LEGv8 instruction at a time through DECODE/EXEC/MEM/WB.
// Optional performance counters are built when EXEC_SEQ_PERF_EN is defined.
module exec_sequencer
    import exec_seq_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned PERF_W      = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] OPCode,
    input  logic        zero,
    input  logic        negative,
    input  logic        overflow,
    input  logic        mem_ready,
    output logic        Reg2Loc,
    output logic [1:0]  ALUSrc,
    output logic [2:0]  ALUCntrl,
    output logic        MemtoReg,
    output logic        LDURB,
    output logic        MOVZ,
    output logic        MOVK,
    output logic [3:0]  xfer_size,
    output logic        read_enable,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        flag_we,
    output logic        pc_we,
    output logic        BrTaken,
    output logic        UncondBr,
    output logic        illegal,
    output logic        mem_err
`ifdef EXEC_SEQ_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_cycles,
    output logic [PERF_W-1:0] perf_retired,
    output logic [PERF_W-1:0] perf_stall
`endif
);

    localparam int unsigned   TMO_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [31:0]      ir_q;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             mem_err_q, mem_err_d;
    ctrl_t            ctrl;
    logic             legal;
    logic             accept;

    assign accept  = instr_valid && (state_q == S_IDLE);
    assign mem_err = mem_err_q;

    exec_seq_decode u_decode (
        .ir    (ir_q),
        .ctrl  (ctrl),
        .legal (legal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            tmo_cnt_q <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
            mem_err_q <= mem_err_d;
            if (accept) begin
                ir_q <= OPCode;
            end
        end
    end

    // Next state and strobes; selects follow the captured IR until the FSM returns to IDLE
    always_comb begin
        state_d     = state_q;
        tmo_cnt_d   = '0;
        mem_err_d   = 1'b0;
        instr_ready = 1'b0;
        Reg2Loc     = 1'b0;
        ALUSrc      = '0;
        ALUCntrl    = '0;
        MemtoReg    = 1'b0;
        LDURB       = 1'b0;
        MOVZ        = 1'b0;
        MOVK        = 1'b0;
        xfer_size   = '0;
        read_enable = 1'b0;
        MemWrite    = 1'b0;
        RegWrite    = 1'b0;
        flag_we     = 1'b0;
        pc_we       = 1'b0;
        BrTaken     = 1'b0;
        UncondBr    = 1'b0;
        illegal     = 1'b0;

        if (state_q != S_IDLE) begin
            Reg2Loc   = ctrl.reg2loc;
            ALUSrc    = ctrl.alu_src;
            ALUCntrl  = ctrl.alu_cntrl;
            MemtoReg  = ctrl.mem_to_reg;
            LDURB     = ctrl.ldurb;
            MOVZ      = ctrl.movz;
            MOVK      = ctrl.movk;
            xfer_size = ctrl.xfer_size;
        end

        case (state_q)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!legal) begin
                    illegal = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (ctrl.kind)
                    K_ALU:   state_d = S_WB;
                    K_ALUF: begin
                        flag_we = 1'b1;
                        state_d = S_WB;
                    end
                    K_LOAD, K_STORE: state_d = S_MEM;
                    K_CBZ: begin
                        pc_we   = 1'b1;
                        BrTaken = zero;
                        state_d = S_IDLE;
                    end
                    K_BLT: begin
                        pc_we   = 1'b1;
                        BrTaken = negative ^ overflow;
                        state_d = S_IDLE;
                    end
                    K_B: begin
                        pc_we    = 1'b1;
                        BrTaken  = 1'b1;
                        UncondBr = 1'b1;
                        state_d  = S_IDLE;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
            S_MEM: begin
                read_enable = (ctrl.kind == K_LOAD);
                MemWrite    = (ctrl.kind == K_STORE);
                // A late mem_ready on the last allowed cycle still completes the access
                if (mem_ready) begin
                    if (ctrl.kind == K_LOAD) begin
                        state_d = S_WB;
                    end else begin
                        pc_we   = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (tmo_cnt_q == TMO_LAST) begin
                    mem_err_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                pc_we    = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef EXEC_SEQ_PERF_EN
    // Free-running cycle, retirement and memory-stall counters
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_cycles  <= '0;
            perf_retired <= '0;
            perf_stall   <= '0;
        end else begin
            perf_cycles <= perf_cycles + PERF_W'(1);
            if (pc_we) begin
                perf_retired <= perf_retired + PERF_W'(1);
            end
            if (state_q == S_MEM && !mem_ready) begin
                perf_stall <= perf_stall + PERF_W'(1);
            end
        end
    end
`else
    localparam int unsigned unused_perf_w = PERF_W;
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed self-checking bench for exec_sequencer: per-cycle strobe and select vectors.
module tb_exec_sequencer;

    logic        clk = 1'b0;
    logic        reset, instr_valid, zero, negative, overflow, mem_ready;
    logic [31:0] OPCode;
    logic        instr_ready, Reg2Loc, MemtoReg, LDURB, MOVZ, MOVK;
    logic [1:0]  ALUSrc;
    logic [2:0]  ALUCntrl;
    logic [3:0]  xfer_size;
    logic        read_enable, MemWrite, RegWrite, flag_we, pc_we, BrTaken, UncondBr, illegal, mem_err;
`ifdef EXEC_SEQ_PERF_EN
    logic [31:0] perf_cycles, perf_retired, perf_stall;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [9:0]  obs;
    logic [13:0] sel;
    assign obs = {instr_ready, read_enable, MemWrite, RegWrite, flag_we, pc_we, BrTaken, UncondBr, illegal, mem_err};
    assign sel = {Reg2Loc, ALUSrc, ALUCntrl, MemtoReg, LDURB, MOVZ, MOVK, xfer_size};

    localparam logic [31:0] I_ADDI  = 32'h9100_1401;
    localparam logic [31:0] I_LDURB = {11'b00111000010, 9'd4, 2'b00, 5'd2, 5'd3};
    localparam logic [31:0] I_LDUR  = {11'b11111000010, 9'd8, 2'b00, 5'd2, 5'd3};
    localparam logic [31:0] I_STUR  = {11'b11111000000, 9'd0, 2'b00, 5'd2, 5'd7};
    localparam logic [31:0] I_SUBS  = {11'b11101011000, 5'd2, 6'd0, 5'd1, 5'd3};
    localparam logic [31:0] I_CBZ   = {8'b10110100, 19'd2, 5'd9};
    localparam logic [31:0] I_BLT   = {8'b01010100, 19'd3, 1'b0, 4'b1011};
    localparam logic [31:0] I_B     = {6'b000101, 26'd12};
    localparam logic [31:0] I_MOVZ  = {9'b110100101, 2'b00, 16'h1234, 5'd4};
    localparam logic [31:0] I_MOVK  = {9'b111100101, 2'b01, 16'h5678, 5'd4};

    // {Reg2Loc, ALUSrc, ALUCntrl, MemtoReg, LDURB, MOVZ, MOVK, xfer_size}
    localparam logic [13:0] S_ADDI  = 14'b0_10_010_0000_0000;
    localparam logic [13:0] S_LDURB = 14'b0_01_010_1100_0001;
    localparam logic [13:0] S_LDUR  = 14'b0_01_010_1000_1000;
    localparam logic [13:0] S_STUR  = 14'b1_01_010_0000_1000;
    localparam logic [13:0] S_SUBS  = 14'b0_00_011_0000_0000;
    localparam logic [13:0] S_CBZ   = 14'b1_00_000_0000_0000;
    localparam logic [13:0] S_MOVZ  = 14'b1_00_000_0010_0000;
    localparam logic [13:0] S_MOVK  = 14'b1_00_000_0001_0000;

    // {ready, re, mw, rw, fwe, pcwe, br, unc, ill, merr}
    localparam logic [9:0] O_IDLE = 10'b1000000000;
    localparam logic [9:0] O_BUSY = 10'b0000000000;
    localparam logic [9:0] O_WB   = 10'b0001010000;
    localparam logic [9:0] O_RD   = 10'b0100000000;
    localparam logic [9:0] O_WR   = 10'b0010000000;
    localparam logic [9:0] O_WRDN = 10'b0010010000;
    localparam logic [9:0] O_FLAG = 10'b0000100000;
    localparam logic [9:0] O_BRT  = 10'b0000011000;
    localparam logic [9:0] O_BRN  = 10'b0000010000;
    localparam logic [9:0] O_B    = 10'b0000011100;
    localparam logic [9:0] O_ILL  = 10'b0000000010;
    localparam logic [9:0] O_MERR = 10'b1000000001;

    always #5 clk = ~clk;

    exec_sequencer #(.MEM_TIMEOUT(16), .PERF_W(32)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .OPCode(OPCode), .zero(zero), .negative(negative), .overflow(overflow),
        .mem_ready(mem_ready), .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .ALUCntrl(ALUCntrl),
        .MemtoReg(MemtoReg), .LDURB(LDURB), .MOVZ(MOVZ), .MOVK(MOVK), .xfer_size(xfer_size),
        .read_enable(read_enable), .MemWrite(MemWrite), .RegWrite(RegWrite), .flag_we(flag_we),
        .pc_we(pc_we), .BrTaken(BrTaken), .UncondBr(UncondBr), .illegal(illegal), .mem_err(mem_err)
`ifdef EXEC_SEQ_PERF_EN
        , .perf_cycles(perf_cycles), .perf_retired(perf_retired), .perf_stall(perf_stall)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle handshake from IDLE; OPCode is then scrambled to show capture isolation
    task automatic send(input logic [31:0] op);
        instr_valid = 1'b1;
        OPCode      = op;
        tick();
        instr_valid = 1'b0;
        OPCode      = ~op;
    endtask

    task automatic test_reset();
        reset = 1'b1; instr_valid = 1'b0; OPCode = '0; zero = 1'b0;
        negative = 1'b0; overflow = 1'b0; mem_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        n_vec++;
        if (obs !== O_IDLE) begin n_err++; $display("FAIL reset_obs got=%b want=%b", obs, O_IDLE); end
        n_vec++;
        if (sel !== 14'd0) begin n_err++; $display("FAIL reset_sel got=%b want=%b", sel, 14'd0); end
        tick();
    endtask

    task automatic test_addi();
        logic [9:0]  e;
        logic [13:0] es;
        instr_valid = 1'b1; OPCode = I_ADDI;
        tick();
        OPCode = 32'hFFFF_FFFF;
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) instr_valid = 1'b0;
            #1;
            e  = (c == 3) ? O_WB : (c == 4) ? O_IDLE : O_BUSY;
            es = (c == 4) ? 14'd0 : S_ADDI;
            n_vec++;
            if (obs !== e) begin n_err++; $display("FAIL addi_obs c%0d got=%b want=%b", c, obs, e); end
            n_vec++;
            if (sel !== es) begin n_err++; $display("FAIL addi_sel c%0d got=%b want=%b", c, sel, es); end
            tick();
        end
    endtask

    task automatic test_load_byte();
        logic [9:0]  e;
        logic [13:0] es;
        send(I_LDURB);
        for (int c = 1; c <= 7; c++) begin
            mem_ready = (c == 5);
            #1;
            e  = (c <= 2) ? O_BUSY : (c <= 5) ? O_RD : (c == 6) ? O_WB : O_IDLE;
            es = (c == 7) ? 14'd0 : S_LDURB;
            n_vec++;
            if (obs !== e) begin n_err++; $display("FAIL ldurb_obs c%0d got=%b want=%b", c, obs, e); end
            n_vec++;
            if (sel !== es) begin n_err++; $display("FAIL ldurb_sel c%0d got=%b want=%b", c, sel, es); end
            tick();
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_store_timeout();
        logic [9:0] e;
        send(I_STUR);
        for (int c = 1; c <= 20; c++) begin
            #1;
            e = (c <= 2) ? O_BUSY : (c <= 18) ? O_WR : (c == 19) ? O_MERR : O_IDLE;
            n_vec++;
            if (obs !== e) begin n_err++; $display("FAIL stur_tmo c%0d got=%b want=%b", c, obs, e); end
            if (c == 3) begin
                n_vec++;
                if (sel !== S_STUR) begin n_err++; $display("FAIL stur_sel got=%b want=%b", sel, S_STUR); end
            end
            tick();
        end
        // mem_ready on the last allowed MEM cycle completes the store instead of aborting
        send(I_STUR);
        for (int c = 1; c <= 19; c++) begin
            mem_ready = (c == 18);
            #1;
            e = (c <= 2) ? O_BUSY : (c <= 17) ? O_WR : (c == 18) ? O_WRDN : O_IDLE;
            n_vec++;
            if (obs !== e) begin n_err++; $display("FAIL stur_late c%0d got=%b want=%b", c, obs, e); end
            tick();
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_cbz();
        logic [9:0] e;
        for (int z = 1; z >= 0; z--) begin
            zero = (z == 1);
            send(I_CBZ);
            for (int c = 1; c <= 3; c++) begin
                #1;
                e = (c == 1) ? O_BUSY : (c == 2) ? ((z == 1) ? O_BRT : O_BRN) : O_IDLE;
                n_vec++;
                if (obs !== e) begin n_err++; $display("FAIL cbz z%0d c%0d got=%b want=%b", z, c, obs, e); end
                if (c == 2) begin
                    n_vec++;
                    if (sel !== S_CBZ) begin n_err++; $display("FAIL cbz_sel got=%b want=%b", sel, S_CBZ); end
                end
                tick();
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_subs_branch();
        logic [9:0]  e;
        logic [31:0] ops [3];
        logic [9:0]  exe [3];
        negative = 1'b1; overflow = 1'b0;
        send(I_SUBS);
        for (int c = 1; c <= 4; c++) begin
            #1;
            e = (c == 1) ? O_BUSY : (c == 2) ? O_FLAG : (c == 3) ? O_WB : O_IDLE;
            n_vec++;
            if (obs !== e) begin n_err++; $display("FAIL subs c%0d got=%b want=%b", c, obs, e); end
            if (c == 2) begin
                n_vec++;
                if (sel !== S_SUBS) begin n_err++; $display("FAIL subs_sel got=%b want=%b", sel, S_SUBS); end
            end
            tick();
        end
        ops = '{I_BLT, I_BLT, I_B};
        exe = '{O_BRT, O_BRN, O_B};
        for (int k = 0; k < 3; k++) begin
            overflow = (k == 1);
            negative = (k != 2);
            send(ops[k]);
            for (int c = 1; c <= 3; c++) begin
                #1;
                e = (c == 1) ? O_BUSY : (c == 2) ? exe[k] : O_IDLE;
                n_vec++;
                if (obs !== e) begin n_err++; $display("FAIL branch k%0d c%0d got=%b want=%b", k, c, obs, e); end
                tick();
            end
        end
        negative = 1'b0; overflow = 1'b0;
    endtask

    task automatic test_reset_mid();
        send(I_LDUR);
        tick(); tick();
        #1;
        n_vec++;
        if (obs !== O_RD) begin n_err++; $display("FAIL rstmid_mem got=%b want=%b", obs, O_RD); end
        n_vec++;
        if (sel !== S_LDUR) begin n_err++; $display("FAIL rstmid_sel got=%b want=%b", sel, S_LDUR); end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; mem_ready = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            #1;
            n_vec++;
            if (obs !== O_IDLE || sel !== 14'd0) begin
                n_err++; $display("FAIL rstmid_idle c%0d got=%b/%b want=%b/0", c, obs, sel, O_IDLE);
            end
            tick();
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_illegal();
        send(32'hFFFF_FFFF);
        #1;
        n_vec++;
        if (obs !== O_ILL || sel !== 14'd0) begin
            n_err++; $display("FAIL illegal_dec got=%b/%b want=%b/0", obs, sel, O_ILL);
        end
        tick();
        #1;
        n_vec++;
        if (obs !== O_IDLE) begin n_err++; $display("FAIL illegal_idle got=%b want=%b", obs, O_IDLE); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [9:0]  e;
        logic [13:0] es;
        instr_valid = 1'b1; OPCode = I_MOVZ;
        tick();
        OPCode = I_MOVK;
        for (int c = 1; c <= 8; c++) begin
            instr_valid = (c <= 4);
            #1;
            e  = (c == 3 || c == 7) ? O_WB : (c == 4 || c == 8) ? O_IDLE : O_BUSY;
            es = (c <= 3) ? S_MOVZ : (c >= 5 && c <= 7) ? S_MOVK : 14'd0;
            n_vec++;
            if (obs !== e) begin n_err++; $display("FAIL b2b_obs c%0d got=%b want=%b", c, obs, e); end
            n_vec++;
            if (sel !== es) begin n_err++; $display("FAIL b2b_sel c%0d got=%b want=%b", c, sel, es); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_byte();
        test_store_timeout();
        test_cbz();
        test_subs_branch();
        test_reset_mid();
        test_illegal();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
